// File: rtl/mem_pkg.sv
// Shared types and helpers for the byte-serial store path.
// Store sizes follow the req_size encoding; byte lanes are emitted big-endian.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } sz_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_WRITE  = 2'b01,
    ST_FINISH = 2'b10
  } st_e;

  // Number of byte writes for a store size; 0 for the invalid encoding.
  function automatic logic [2:0] size_to_count(input sz_e size);
    logic [2:0] n;
    case (size)
      SZ_BYTE: n = 3'd1;
      SZ_HALF: n = 3'd2;
      SZ_WORD: n = 3'd4;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

  // Byte k of a store, most significant used byte first.
  function automatic logic [7:0] store_byte(input logic [31:0] data,
                                            input sz_e         size,
                                            input logic [1:0]  k);
    logic [7:0] b;
    b = '0;
    case (size)
      SZ_WORD: begin
        case (k)
          2'd0:    b = data[31:24];
          2'd1:    b = data[23:16];
          2'd2:    b = data[15:8];
          default: b = data[7:0];
        endcase
      end
      SZ_HALF: b = (k == 2'd0) ? data[15:8] : data[7:0];
      SZ_BYTE: b = data[7:0];
      default: b = '0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/byte_store_unit.sv
// Serializes a byte/half/word store into one byte RAM write per clock,
// big-endian, with address wrap modulo 2^ADDR_W.
module byte_store_unit
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  input  logic [1:0]        req_size,
  output logic              ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              done,
  output logic              err
);

  st_e               r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_data;
  sz_e               r_size;
  logic [1:0]        r_cnt;
  logic [1:0]        r_last;
  logic              r_err;

  sz_e               w_size;
  logic [2:0]        w_count;
  logic [2:0]        w_count_m1;
  logic              w_accept;

  assign w_size     = sz_e'(req_size);
  assign w_count    = size_to_count(w_size);
  assign w_count_m1 = w_count - 3'd1;
  assign w_accept   = req && (r_state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_data  <= '0;
      r_size  <= SZ_BYTE;
      r_cnt   <= '0;
      r_last  <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_addr <= req_addr;
            r_data <= req_data;
            r_size <= w_size;
            r_cnt  <= '0;
            r_last <= w_count_m1[1:0];
            if (w_size == SZ_BAD) begin
              r_err   <= 1'b1;
              r_state <= ST_FINISH;
            end else begin
              r_err   <= 1'b0;
              r_state <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          if (r_cnt == r_last) begin
            r_state <= ST_FINISH;
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        ST_FINISH: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Outputs decode only from state, counter and latched fields; ready is state-only.
  always_comb begin
    ready     = (r_state == ST_IDLE);
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    done      = 1'b0;
    err       = 1'b0;
    case (r_state)
      ST_WRITE: begin
        mem_we    = 1'b1;
        mem_addr  = r_addr + ADDR_W'(r_cnt);
        mem_wdata = store_byte(r_data, r_size, r_cnt);
      end
      ST_FINISH: begin
        done = !r_err;
        err  = r_err;
      end
      default: begin
      end
    endcase
  end

endmodule
